// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the all-dark pattern and the active-low hex glyph table.
package seg7_scan_driver_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry 0 is the rightmost element; every glyph keeps dp (bit 7) dark.
    localparam logic [15:0][7:0] HEX_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_pattern(input logic [3:0] nibble, input logic dp);
        logic [7:0] pat;
        pat         = HEX_TABLE[nibble];
        pat[SEG_DP] = ~dp;
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the scan driver: scan control and digit data in,
// multiplexed anode/segment drive and frame pulse out.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 8
);
    logic                    en;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blank;
    logic [N_DIGITS-1:0]     an;
    logic [7:0]              seg;
    logic                    frame_done;

    modport master (
        output en, data, dp_in, blank,
        input  an, seg, frame_done
    );

    modport slave (
        input  en, data, dp_in, blank,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational hex-nibble to active-low 7-segment pattern, dp in bit 7.
module seg7_hex_encode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);
    assign o_seg = hex_pattern(i_nibble, i_dp);
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with per-frame input snapshot and
// anti-ghosting guard. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_driver_if.slave      bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    logic [CW-1:0]           r_slot_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_snap_data;
    logic [N_DIGITS-1:0]     r_snap_dp;
    logic [N_DIGITS-1:0]     r_snap_blank;
    logic [N_DIGITS-1:0]     r_an;
    logic [7:0]              r_seg;
    logic                    r_frame_done;

    logic                    w_slot_wrap;
    logic                    w_frame_wrap;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic [7:0]              w_enc;
    logic                    w_digit_on;
    logic [N_DIGITS-1:0]     w_lz_keep;
    logic [N_DIGITS-1:0]     w_an_next;

    assign w_slot_wrap  = (r_slot_cnt == CNT_LAST);
    assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
    assign w_nibble     = r_snap_data[{r_idx, 2'b00} +: 4];
    assign w_dp         = r_snap_dp[r_idx];

    seg7_hex_encode u_enc (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_enc)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit stays lit if it or any higher digit is nonzero or carries a dp.
    logic [N_DIGITS:0] w_sig_above;
    assign w_sig_above[N_DIGITS] = 1'b0;
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
        assign w_sig_above[gi] = w_sig_above[gi+1] | (|r_snap_data[4*gi +: 4]) | r_snap_dp[gi];
        if (gi == 0) begin : g_first
            assign w_lz_keep[gi] = 1'b1;
        end else begin : g_rest
            assign w_lz_keep[gi] = w_sig_above[gi];
        end
    end
`else
    assign w_lz_keep = '1;
`endif

    assign w_digit_on = bus.en && (r_slot_cnt >= CNT_GUARD)
                        && !r_snap_blank[r_idx] && w_lz_keep[r_idx];

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_an
        assign w_an_next[gi] = !(w_digit_on && (r_idx == IW'(gi)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_idx        <= '0;
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_an         <= '1;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_digit_on ? w_enc : SEG_OFF;
            r_frame_done <= bus.en && w_frame_wrap;
            if (bus.en) begin
                if (w_slot_wrap) begin
                    r_slot_cnt <= '0;
                    if (r_idx == IDX_LAST) begin
                        r_idx        <= '0;
                        r_snap_data  <= bus.data;
                        r_snap_dp    <= bus.dp_in;
                        r_snap_blank <= bus.blank;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=4, GUARD=1):
// a cycle reference model feeds a scoreboard queue, plus directed scenario checks.
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GD = 1;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] enc_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_data  = '0;
    logic [3:0]  m_dp    = '0;
    logic [3:0]  m_blank = '0;

    logic [3:0]  o_an;
    logic [7:0]  o_seg;
    logic        o_fd;
    logic [7:0]  cap_seg [4];
    logic [3:0]  cap_lit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h want %h", tag, cyc, got, want);
        end
    endtask

    function automatic logic lz_keep(input int d);
        logic k;
        k = !LZ || (d == 0);
        for (int j = N - 1; j >= d; j--)
            if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) k = 1'b1;
        return k;
    endfunction

    task automatic clear_cap();
        cap_lit = '0;
        for (int i = 0; i < N; i++) cap_seg[i] = 8'hFF;
    endtask

    // One clock: predict outputs from the model, advance it, then compare.
    task automatic tick();
        exp_t       e;
        logic       on;
        logic [3:0] nib;
        if (!rst_n) begin
            e = '{an: 4'hF, seg: 8'hFF, fd: 1'b0};
            m_cnt = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
        end else begin
            nib   = m_data[4*m_idx +: 4];
            on    = bus.en && (m_cnt >= GD) && !m_blank[m_idx] && lz_keep(m_idx);
            e.an  = on ? ~(4'b0001 << m_idx) : 4'hF;
            e.seg = on ? {~m_dp[m_idx], enc_tbl[nib][6:0]} : 8'hFF;
            e.fd  = bus.en && (m_cnt == SD - 1) && (m_idx == N - 1);
            if (bus.en) begin
                if (m_cnt == SD - 1) begin
                    m_cnt = 0;
                    if (m_idx == N - 1) begin
                        m_idx   = 0;
                        m_data  = bus.data;
                        m_dp    = bus.dp_in;
                        m_blank = bus.blank;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        o_an  = bus.an;
        o_seg = bus.seg;
        o_fd  = bus.frame_done;
        e = sb_q.pop_front();
        chk("an", o_an, e.an);
        chk("seg", o_seg, e.seg);
        chk("fd", o_fd, e.fd);
        $display("cyc %0d rst_n %0b en %0b an %b seg %h fd %0b", cyc, rst_n, bus.en, o_an, o_seg, o_fd);
        for (int i = 0; i < N; i++)
            if (!o_an[i]) begin
                cap_seg[i] = o_seg;
                cap_lit[i] = 1'b1;
            end
    endtask

    task automatic run_to_fd(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_fd && n < limit);
        chk("fd_within_limit", o_fd, 1'b1);
    endtask

    int n;

    initial begin
        bus.en = 1'b1; bus.data = '0; bus.dp_in = '0; bus.blank = '0;
        clear_cap();

        // Reset and first frame
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_an", o_an, 4'hF);
        chk("rst_seg", o_seg, 8'hFF);
        chk("rst_fd", o_fd, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("guard_an", o_an, 4'hF);
        chk("guard_seg", o_seg, 8'hFF);
        tick();
        chk("d0_an", o_an, 4'hE);
        chk("d0_seg", o_seg, 8'hC0);
        bus.data = 16'hF1A5; bus.dp_in = 4'b0001;
        run_to_fd(40, n);
        chk("first_fd_cycle", n + 2, 16);

        // Scan of captured snapshot
        clear_cap();
        run_to_fd(40, n);
        chk("frame_len", n, 16);
        chk("scan_lit", cap_lit, 4'hF);
        chk("scan_d0", cap_seg[0], 8'h12);
        chk("scan_d1", cap_seg[1], 8'h88);
        chk("scan_d2", cap_seg[2], 8'hF9);
        chk("scan_d3", cap_seg[3], 8'h8E);

        // Tearing: mid-frame change must wait for the next frame
        clear_cap();
        repeat (6) tick();
        bus.data = 16'h3333; bus.dp_in = 4'b0000;
        run_to_fd(40, n);
        chk("tear_d1", cap_seg[1], 8'h88);
        chk("tear_d2", cap_seg[2], 8'hF9);
        chk("tear_d3", cap_seg[3], 8'h8E);
        clear_cap();
        run_to_fd(40, n);
        chk("new_d0", cap_seg[0], 8'hB0);
        chk("new_d3", cap_seg[3], 8'hB0);

        // Enable low mid-slot freezes the scan
        repeat (5) tick();
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en0_an", o_an, 4'hF);
            chk("en0_seg", o_seg, 8'hFF);
        end
        bus.en = 1'b1;
        tick();
        chk("resume_an", o_an, 4'hD);
        run_to_fd(40, n);
        chk("en_frame_len", n + 16, 26);

        // Blanked digit never lit
        bus.blank = 4'b0100;
        run_to_fd(40, n);
        clear_cap();
        run_to_fd(40, n);
        chk("blank_lit", cap_lit, 4'b1011);
        bus.blank = 4'b0000;

        // Reset mid-frame
        bus.data = 16'h7777;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_an", o_an, 4'hF);
        chk("rst_mid_seg", o_seg, 8'hFF);
        chk("rst_mid_fd", o_fd, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_guard", o_an, 4'hF);
        tick();
        chk("rst_mid_d0_an", o_an, 4'hE);
        chk("rst_mid_d0_seg", o_seg, 8'hC0);
        run_to_fd(40, n);
        chk("rst_mid_fd_cycle", n + 2, 16);
        clear_cap();
        run_to_fd(40, n);
        chk("rst_mid_capture", cap_seg[3], 8'hF8);

        // Leading zeros
        bus.data = 16'h0030;
        run_to_fd(40, n);
        clear_cap();
        run_to_fd(40, n);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("lz_lit", cap_lit, 4'b0011);
        chk("lz_d1", cap_seg[1], 8'hB0);
        chk("lz_d0", cap_seg[0], 8'hC0);
        bus.dp_in = 4'b0100;
        run_to_fd(40, n);
        clear_cap();
        run_to_fd(40, n);
        chk("lz_dp_lit", cap_lit, 4'b0111);
        chk("lz_dp_d2", cap_seg[2], 8'h40);
        bus.data = 16'h0000; bus.dp_in = 4'b0000;
        run_to_fd(40, n);
        clear_cap();
        run_to_fd(40, n);
        chk("lz_zero_lit", cap_lit, 4'b0001);
`else
        chk("lz_off_lit", cap_lit, 4'b1111);
        chk("lz_off_d3", cap_seg[3], 8'hC0);
        chk("lz_off_d1", cap_seg[1], 8'hB0);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 300; i++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.data  = 16'($urandom);
                bus.dp_in = 4'($urandom);
                bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8: digit count; legal range 1..16.
REQ-002 Parameter SCAN_DIV, default 100000: clock cycles per digit slot; legal range GUARD+2 or more.
REQ-003 Parameter GUARD, default 4: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 or more.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 en  in  1  scan enable; low blanks the display and freezes scanning.
REQ-007 data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost.
REQ-008 dp_in  in  N_DIGITS  decimal point request per digit, active-high.
REQ-009 blank  in  N_DIGITS  force digit dark, active-high.
REQ-010 an  out  N_DIGITS  digit enables, active-low, at most one low at any time.
REQ-011 seg  out  8  segments, active-low; bit0=a .. bit6=g, bit7=dp.
REQ-012 frame_done  out  1  one-cycle pulse on completion of each full scan.

Function
REQ-013 The slot counter shall count 0..SCAN_DIV-1 while en=1 and wrap to 0; at wrap, the digit index shall advance 0,1,..,N_DIGITS-1 and then wrap to 0.
REQ-014 On the cycle the index wraps from N_DIGITS-1 to 0, data, dp_in and blank shall be captured into a snapshot, and frame_done shall pulse for exactly 1 cycle.
REQ-015 Displayed values shall come only from the snapshot; mid-frame input changes shall not appear until the next frame (no tearing).
REQ-016 an and seg shall be registered: 1 cycle of latency from the counter/index state.
REQ-017 an[idx] shall be low only when en=1, slot count is GUARD or more, and the snapshot blank[idx]=0; otherwise an shall be all ones.
REQ-018 Encoding for hex 0..F shall be C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (bits 6:0 with bit7=1); bit7 shall be 0 when the snapshot dp is set.
REQ-019 seg shall be 8'hFF whenever an is all ones.
REQ-020 en low shall hold the slot counter and index at their current values, and shall suppress frame_done and snapshot capture; on en high, scanning shall resume from the held state.
REQ-021 N_DIGITS=1 shall wrap the index every slot, and frame_done shall pulse every SCAN_DIV cycles.

Reset
REQ-022 While rst_n=0 at a clock edge: the slot counter, index and snapshot shall be 0, an shall be all ones, seg shall be 8'hFF, and frame_done shall be 0.
REQ-023 A reset asserted mid-slot or mid-frame shall abandon the frame; the first frame after release shall display the reset snapshot (all dark through guard, then digit 0..) and shall capture live inputs at its end.

Configuration
REQ-024 The macro SEG7_LEADING_ZERO_BLANK_EN shall, when defined, blank every digit above the highest nonzero snapshot digit, stopping at the first digit (scanning down from the top) whose snapshot dp is set; digit 0 shall never be suppressed.
REQ-025 When SEG7_LEADING_ZERO_BLANK_EN is undefined, all non-blanked digits shall be shown, including leading zeros.

Structure
REQ-026 A shared package shall hold the segment bit-position constants, the SEG_OFF constant (8'hFF) and the 16-entry hex pattern table.
REQ-027 Sub-module seg7_hex_encode (combinational: nibble and dp in, 8-bit active-low pattern out) shall perform the encoding; the scan driver shall instantiate it once.

Verification
REQ-028 The bench shall cover the following scenarios, using N_DIGITS=4, SCAN_DIV=4, GUARD=1 unless stated otherwise.
REQ-029 Reset scenario: release reset with data=16'h0000 and en=1 -> an=4'b1111 and seg=FF through the guard cycle, then an=4'b1110 and seg=C0; frame_done shall first pulse 16 cycles after release.
REQ-030 Scan scenario: data=16'hF1A5 and dp_in=4'b0001, after 1 frame -> slots shall show 12 (5 with dp), 88, F9, 8E on an 1110, 1101, 1011, 0111 respectively.
REQ-031 Tearing scenario: change data mid-frame -> the old values shall remain for the rest of that frame, and the new values shall appear only after the frame_done pulse.
REQ-032 Enable/blank scenario: en=0 for 10 cycles mid-slot -> an shall be all ones and the counters frozen, with scanning resuming in the same slot; blank=4'b0100 -> an bit 2 shall never go low.
REQ-033 Leading-zero scenario, macro defined: data=16'h0030 -> digits 3 and 2 dark, digits 1 and 0 shown; dp_in=4'b0100 -> digit 2 shows C0 with dp (bit7=0, i.e. 40); data=16'h0000 -> only digit 0 lit.
REQ-034 Reset-mid-frame scenario: assert rst_n=0 for 1 cycle mid-frame -> all outputs shall reach their reset values at the next edge, and the sequence shall restart at index 0.
